lamp_shift_driver: RTL and testbench

Downstream stage of the bound flasher. Consumes the parallel 16-bit lamps vector and streams it to an external serial-in/parallel-out LED shift-register chain (74HC595-style) over a 3-wire interface: sclk, sdata, latch. A frame is sent once after reset and again whenever the lamps value differs from the last value sent. Intermediate values that occur during a frame are coalesced.

---
 rtl/lamp_shift_driver.sv | 148 ++++++++++++++
 tb/tb_lamp_shift_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lamp_shift_driver.sv
// Serialises the parallel lamp pattern onto a 74HC595-style chain (sclk/sdata/latch).
// A frame is sent after reset and whenever lamps differs from the last value sent.
module lamp_shift_driver #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lamps,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   sent_q, sent_d;
    logic               first_q, first_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic               sclk_q, sclk_d;
    logic               sdata_q, sdata_d;
    logic               latch_q, latch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_end;

    // Bit that leaves the chain first for a given (possibly pre-shifted) word.
    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        sent_d    = sent_q;
        first_d   = first_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        sdata_d   = sdata_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (first_q || (lamps != sent_q)) begin
                    shadow_d  = lamps;
                    sent_d    = lamps;
                    first_d   = 1'b0;
                    sdata_d   = lead_bit(lamps);
                    bit_idx_d = '0;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        sdata_d = 1'b0;
                        state_d = LATCH;
                    end else begin
                        // Shadow shifts so the next bit is always at the lead position.
                        bit_idx_d = bit_idx_q + 1'b1;
                        shadow_d  = MSB_FIRST ? (shadow_q << 1) : (shadow_q >> 1);
                        sdata_d   = lead_bit(shadow_d);
                        state_d   = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        sclk_d  = (state_d == SHIFT_HI);
        latch_d = (state_d == LATCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            sent_q    <= '0;
            first_q   <= 1'b1;
            div_q     <= '0;
            bit_idx_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            sent_q    <= sent_d;
            first_q   <= first_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign latch      = latch_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_lamp_shift_driver.sv
// Directed bench for lamp_shift_driver: default instance plus an LSB-first, CLK_DIV=1 instance.
module tb_lamp_shift_driver;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [15:0] lamps, lamps2;
    logic        sclk, sdata, latch, busy, fd;
    logic        sclk2, sdata2, latch2, busy2, fd2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lamp_shift_driver #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .lamps(lamps), .sclk(sclk), .sdata(sdata),
        .latch(latch), .busy(busy), .frame_done(fd)
    );

    lamp_shift_driver #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst_n(rst2_n), .lamps(lamps2), .sclk(sclk2), .sdata(sdata2),
        .latch(latch2), .busy(busy2), .frame_done(fd2)
    );

    // Frame monitor for the default instance; bits accumulate in arrival order.
    int          nfr = 0, cur_rises = 0, busy_cnt = 0, latch_cnt = 0, total_rises = 0;
    int          f_rises = 0, f_busy = 0, f_latch = 0;
    logic [15:0] acc = '0;
    logic        prev = 1'b0;
    logic [15:0] fw[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            acc = '0; cur_rises = 0; busy_cnt = 0; latch_cnt = 0; prev = 1'b0;
        end else begin
            if (sclk && !prev) begin
                acc = {acc[14:0], sdata};
                cur_rises++;
                total_rises++;
            end
            prev = sclk;
            if (busy)  busy_cnt++;
            if (latch) latch_cnt++;
            if (fd) begin
                fw.push_back(acc);
                f_rises = cur_rises; f_busy = busy_cnt; f_latch = latch_cnt;
                nfr++;
                acc = '0; cur_rises = 0; busy_cnt = 0; latch_cnt = 0;
            end
        end
    end

    // LSB-first instance: first bit received lands in bit 0.
    int          nfr2 = 0, rises2 = 0, busy2_cnt = 0, latch2_cnt = 0;
    int          f2_rises = 0, f2_busy = 0, f2_latch = 0;
    logic [15:0] acc2 = '0, fw2 = '0;
    logic        prev2 = 1'b0;

    always @(negedge clk) begin
        if (!rst2_n) begin
            acc2 = '0; rises2 = 0; busy2_cnt = 0; latch2_cnt = 0; prev2 = 1'b0;
        end else begin
            if (sclk2 && !prev2) begin
                acc2 = {sdata2, acc2[15:1]};
                rises2++;
            end
            prev2 = sclk2;
            if (busy2)  busy2_cnt++;
            if (latch2) latch2_cnt++;
            if (fd2) begin
                fw2 = acc2;
                f2_rises = rises2; f2_busy = busy2_cnt; f2_latch = latch2_cnt;
                nfr2++;
                acc2 = '0; rises2 = 0; busy2_cnt = 0; latch2_cnt = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_nfr(input int target, input int budget, input string tag);
        int n = 0;
        while (nfr < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, nfr, target);
    endtask

    task automatic wait_rises(input int k, input string tag);
        int n = 0;
        while (cur_rises < k && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, cur_rises, k);
    endtask

    initial begin
        int r;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        lamps  = 16'h0000;
        lamps2 = 16'hA5C3;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sclk",  sclk,  0);
        check_eq("rst_sdata", sdata, 0);
        check_eq("rst_latch", latch, 0);
        check_eq("rst_busy",  busy,  0);
        check_eq("rst_done",  fd,    0);

        // 1: first frame after reset, all zeros
        rst_n = 1'b1;
        wait_nfr(1, 400, "t1_frame");
        check_eq("t1_word",  fw[0],   16'h0000);
        check_eq("t1_rises", f_rises, 16);
        check_eq("t1_busy",  f_busy,  132);
        check_eq("t1_latch", f_latch, 4);
        r = total_rises;
        repeat (1000) @(posedge clk);
        #1;
        check_eq("t1_quiet_rises",  total_rises, r);
        check_eq("t1_quiet_frames", nfr, 1);

        // 2: idle change starts a frame one cycle later
        lamps = 16'h8001;
        @(negedge clk);
        check_eq("t2_busy_pre", busy, 0);
        @(negedge clk);
        check_eq("t2_busy_post", busy, 1);
        wait_nfr(2, 400, "t2_frame");
        check_eq("t2_word",  fw[1],   16'h8001);
        check_eq("t2_rises", f_rises, 16);
        check_eq("t2_busy",  f_busy,  132);
        check_eq("t2_latch", f_latch, 4);

        // 3: mid-frame changes are coalesced into one follow-up frame
        lamps = 16'h0003;
        wait_rises(5, "t3_bit5");
        lamps = 16'h0007;
        wait_rises(10, "t3_bit10");
        lamps = 16'h000F;
        wait_nfr(3, 400, "t3_frame_a");
        check_eq("t3_word_a", fw[2], 16'h0003);
        wait_nfr(4, 400, "t3_frame_b");
        check_eq("t3_word_b", fw[3], 16'h000F);
        repeat (300) @(posedge clk);
        #1;
        check_eq("t3_no_extra", nfr, 4);

        // 4: excursion that returns to the value being sent yields no frame
        lamps = 16'h00FF;
        wait_rises(4, "t4_bit4");
        lamps = 16'h0F00;
        wait_rises(8, "t4_bit8");
        lamps = 16'h00FF;
        wait_nfr(5, 400, "t4_frame");
        check_eq("t4_word", fw[4], 16'h00FF);
        repeat (300) @(posedge clk);
        #1;
        check_eq("t4_no_extra", nfr, 5);
        check_eq("t4_idle_busy", busy, 0);

        // 5: reset mid-frame drops outputs at once, then a full frame resends
        lamps = 16'hFFFF;
        wait_rises(7, "t5_bit7");
        check_eq("t5_sdata_pre", sdata, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_sclk",  sclk,  0);
        check_eq("t5_sdata", sdata, 0);
        check_eq("t5_latch", latch, 0);
        check_eq("t5_busy",  busy,  0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_nfr(6, 400, "t5_frame");
        check_eq("t5_word",  fw[5],   16'hFFFF);
        check_eq("t5_rises", f_rises, 16);
        check_eq("t5_busy_len", f_busy, 132);
        check_eq("t5_latch_len", f_latch, 4);

        // 6: LSB-first, CLK_DIV=1
        rst2_n = 1'b1;
        begin
            int n = 0;
            while (nfr2 < 1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check_eq("t6_frame", nfr2, 1);
        check_eq("t6_word",  fw2,      16'hA5C3);
        check_eq("t6_rises", f2_rises, 16);
        check_eq("t6_busy",  f2_busy,  33);
        check_eq("t6_latch", f2_latch, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
